// File: rtl/pow_pkg.sv
// Shared constants, FSM state type and core-id width helper for the PoW dispatch block.
package pow_pkg;

    localparam int NONCE_W        = 64;
    localparam int TARGET_W       = 64;
    localparam int JOB_W          = 640;
    localparam int HASH_CYCLE_DEF = 14;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int cid_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pow_result_fifo.sv
// Result FIFO: synchronous storage of {core id, nonce} with a combinational head read.
// Latency: a push at edge t is visible at the head after edge t (when the FIFO was empty).
// Backpressure: a push at full is taken only together with a pop; a pop at empty is ignored.
module pow_result_fifo
    import pow_pkg::*;
#(
    parameter int DW    = 65,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_push,
    input  logic [DW-1:0] i_din,
    input  logic          i_pop,
    output logic [DW-1:0] o_dout,
    output logic          o_full,
    output logic          o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dout    = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/pow_dispatch.sv
// PoW core controller: staggered starts, job fan-out, RR result collection (DROP_CNT_EN adds drop counter).
// Latency: start of core 0 one cycle after load; core_store -> out_valid two edges.
// Backpressure: out_valid/out_ready; a full FIFO stalls the arbiter, repeat stores on a held core drop.
module pow_dispatch
    import pow_pkg::*;
#(
    parameter int NCORE      = 2,
    parameter int HASH_CYCLE = HASH_CYCLE_DEF,
    parameter int NONCE_W    = pow_pkg::NONCE_W,
    parameter int JOB_W      = pow_pkg::JOB_W,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic                        halt,
    input  logic [JOB_W-1:0]            job,
    output logic [TARGET_W-1:0]         core_target,
    output logic [JOB_W-TARGET_W-1:0]   core_blob,
    output logic                        core_load,
    output logic                        core_flush,
    output logic [NCORE-1:0]            core_start,
    input  logic [NCORE*NONCE_W-1:0]    core_nonce,
    input  logic [NCORE-1:0]            core_store,
    output logic [NONCE_W-1:0]          out_nonce,
    output logic [cid_w(NCORE)-1:0]     out_core,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy,
    output logic [15:0]                 drop_cnt
);

    localparam int CID_W  = cid_w(NCORE);
    localparam int PH_W   = cid_w(HASH_CYCLE);
    localparam int STRIDE = HASH_CYCLE / NCORE;
    localparam int FDW    = CID_W + NONCE_W;

    state_t                     r_state;
    logic [PH_W-1:0]            r_phase;
    logic [PH_W-1:0]            w_phase_sel;
    logic [NCORE-1:0]           r_start;
    logic [NCORE-1:0]           w_start_vec;
    logic                       r_load;
    logic                       r_flush;
    logic [TARGET_W-1:0]        r_target;
    logic [JOB_W-TARGET_W-1:0]  r_blob;

    logic [NCORE-1:0]           r_pend;
    logic [NONCE_W-1:0]         r_pnonce [NCORE];
    logic [CID_W-1:0]           r_ptr;
    logic [NCORE-1:0]           w_grant;
    logic [NCORE-1:0]           w_accept;
    logic [CID_W-1:0]           w_gidx;
    logic                       w_gvld;
    int                         w_rr_idx;

    logic                       w_fifo_full;
    logic                       w_fifo_empty;
    logic                       w_pop;
    logic                       w_can_push;
    logic [FDW-1:0]             w_fifo_dout;

    // Phase of the start strobe being registered this edge; load forces phase 0.
    always_comb begin
        if (load || r_phase == PH_W'(HASH_CYCLE - 1)) begin
            w_phase_sel = '0;
        end else begin
            w_phase_sel = r_phase + PH_W'(1);
        end
        w_start_vec = '0;
        for (int i = 0; i < NCORE; i++) begin
            w_start_vec[i] = (int'(w_phase_sel) == STRIDE * i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_phase  <= '0;
            r_start  <= '0;
            r_load   <= 1'b0;
            r_flush  <= 1'b1;
            r_target <= '0;
            r_blob   <= '0;
        end else begin
            r_load <= load;
            if (load) begin
                r_state  <= ST_RUN;
                r_phase  <= w_phase_sel;
                r_start  <= w_start_vec;
                r_flush  <= 1'b0;
                r_target <= job[TARGET_W-1:0];
                r_blob   <= job[JOB_W-1:TARGET_W];
            end else if (r_state == ST_RUN && !halt) begin
                r_phase <= w_phase_sel;
                r_start <= w_start_vec;
            end else begin
                r_state <= ST_IDLE;
                r_phase <= '0;
                r_start <= '0;
                r_flush <= 1'b1;
            end
        end
    end

    assign core_target = r_target;
    assign core_blob   = r_blob;
    assign core_load   = r_load;
    assign core_flush  = r_flush;
    assign core_start  = r_start;
    assign busy        = (r_state == ST_RUN);

    assign w_pop      = out_ready && !w_fifo_empty;
    assign w_can_push = !w_fifo_full || w_pop;

    // Round-robin search starting at r_ptr; grants only when the FIFO can take the entry.
    always_comb begin
        w_grant  = '0;
        w_gidx   = '0;
        w_gvld   = 1'b0;
        w_rr_idx = 0;
        for (int k = 0; k < NCORE; k++) begin
            w_rr_idx = int'(r_ptr) + k;
            if (w_rr_idx >= NCORE) w_rr_idx = w_rr_idx - NCORE;
            if (!w_gvld && w_can_push && r_pend[w_rr_idx]) begin
                w_gvld            = 1'b1;
                w_gidx            = CID_W'(w_rr_idx);
                w_grant[w_rr_idx] = 1'b1;
            end
        end
    end

    assign w_accept = core_store & (~r_pend | w_grant);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_ptr  <= '0;
        end else begin
            if (w_gvld) begin
                r_ptr <= (int'(w_gidx) == NCORE - 1) ? '0 : w_gidx + CID_W'(1);
            end
            for (int i = 0; i < NCORE; i++) begin
                if (load) begin
                    r_pend[i] <= 1'b0;
                end else if (w_accept[i]) begin
                    r_pend[i] <= 1'b1;
                end else if (w_grant[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCORE; i++) begin
            if (w_accept[i]) r_pnonce[i] <= core_nonce[i*NONCE_W +: NONCE_W];
        end
    end

    pow_result_fifo #(
        .DW    (FDW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (load),
        .i_push  (w_gvld),
        .i_din   ({w_gidx, r_pnonce[w_gidx]}),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign out_core  = w_fifo_dout[FDW-1:NONCE_W];
    assign out_nonce = w_fifo_dout[NONCE_W-1:0];
    assign out_valid = !w_fifo_empty;

`ifdef DROP_CNT_EN
    logic [NCORE-1:0] w_drop;
    logic [16:0]      w_drop_sum;
    logic [15:0]      r_drop_cnt;

    always_comb begin
        w_drop     = core_store & r_pend & ~w_grant;
        w_drop_sum = {1'b0, r_drop_cnt};
        for (int i = 0; i < NCORE; i++) begin
            w_drop_sum = w_drop_sum + 17'(w_drop[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || load) begin
            r_drop_cnt <= '0;
        end else if (w_drop_sum > 17'h0FFFF) begin
            r_drop_cnt <= 16'hFFFF;
        end else begin
            r_drop_cnt <= w_drop_sum[15:0];
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: doc/pow_dispatch.md
Name: pow_dispatch

Overview:
Parametrised successor to the K12 PoW core controller. It issues the staggered per-core start strobes for NCORE K12_PoW pipelines and fans the job out to them. It collects found nonces from every core without bus contention: per-core capture, round-robin arbitration, then a result FIFO with a valid/ready output. It sits between the job-load logic and the host result interface.

Parameters:
NCORE, 2, number of K12_PoW cores; 1 <= NCORE <= HASH_CYCLE
HASH_CYCLE, 14, pipeline initiation period in clocks; start stride = HASH_CYCLE/NCORE (integer division)
NONCE_W, 64, nonce width
JOB_W, 640, job width; target = job[63:0], blob = job[JOB_W-1:64]
FIFO_DEPTH, 8, result FIFO entries; power of 2, >= 2

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset, sampled on rising clk
load  in  1  one-cycle pulse: latch new job, restart phase
halt  in  1  level: stop issuing starts
job  in  JOB_W  job word, sampled when load=1
core_target  out  64  registered target to all cores
core_blob  out  JOB_W-64  registered blob to all cores
core_load  out  1  registered copy of load (one cycle later)
core_flush  out  1  core reset request; high in IDLE
core_start  out  NCORE  per-core start strobes
core_nonce  in  NCORE*NONCE_W  per-core nonce, core i at [i*NONCE_W +: NONCE_W]
core_store  in  NCORE  per-core nonce-valid pulse
out_nonce  out  NONCE_W  FIFO head nonce
out_core  out  max(1,clog2(NCORE))  core index of the head entry
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts the head when valid&ready
busy  out  1  state==RUN
drop_cnt  out  16  dropped-result counter (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE, phase=0, core_start=0, core_load=0, core_flush=1, target/blob=0, all pending flags clear, FIFO empty, out_valid=0, busy=0, drop_cnt=0, arbiter pointer=0.
- FSM states are IDLE and RUN.
- IDLE->RUN on load. RUN->IDLE on halt with load=0. load in RUN restarts with the new job.
- load and halt in the same cycle: load wins, state=RUN.
- On load: latch target/blob, phase<=0, pulse core_load next cycle, clear pending flags and FIFO; stale results are discarded. halt leaves FIFO and pending contents intact.
- RUN: phase counts 0..HASH_CYCLE-1 and wraps to 0.
  - core_start[i] is registered: high for one cycle when phase==(HASH_CYCLE/NCORE)*i.
  - The first start of core 0 occurs the cycle after load.
  - Each core is started once per HASH_CYCLE clocks.
- IDLE: core_start=0, phase held at 0, core_flush=1. In RUN, core_flush=0.
- Capture: core_store[i] at edge t sets pending[i] and latches the nonce.
  - If pending[i] is already set and not granted at t, the new result is dropped and drop_cnt increments, saturating at 16'hFFFF.
  - If pending[i] is granted at t, the new store is accepted; no drop.
- Arbiter: round-robin over pending flags, one grant per cycle, only when the FIFO is not full (FIFO push and pop allowed in the same cycle). Pointer moves to granted+1 mod NCORE.
- Latency: store at edge t -> FIFO write at edge t+1 (if granted) -> out_valid high after edge t+1.
- FIFO: full with no pop stalls the arbiter; pending flags hold. Pop on empty has no effect. Simultaneous push and pop at full is allowed.
- Outputs stay stable while out_valid=1 and out_ready=0.

Optional Feature:
DROP_CNT_EN
- Defined: drop_cnt counts dropped results as above; cleared by reset and by load.
- Undefined: no counter logic; drop_cnt tied to 0; drops are still silent.

Decomposition:
- Package pow_pkg: NONCE_W, TARGET_W=64, JOB_W, default HASH_CYCLE, and a clog2-based core-id width function.
- One sub-module, pow_result_fifo: a synchronous FIFO with push/pop/full/empty and a data width of NONCE_W+core-id width.

Test Plan:
- Reset then load with job=0x0123…, NCORE=2, HASH_CYCLE=14: core_start[0] high at cycles 1,15,29; core_start[1] high at cycles 8,22; core_target=job[63:0].
- core_store[1] pulse with nonce 0xDEAD: out_valid rises 2 cycles later with out_nonce=0xDEAD, out_core=1.
- All NCORE stores in the same cycle, out_ready=1: results leave in round-robin order 0,1,…, one per cycle.
- out_ready=0, FIFO_DEPTH=8, 10 stores to core 0 spaced 2 cycles apart: 8 entries held, 9th pending, 10th dropped; drop_cnt=1 with DROP_CNT_EN, 0 without.
- halt during RUN: core_start goes to 0 the next cycle, core_flush=1, FIFO contents are still drained after out_ready=1.
- load and halt asserted together, and rst_n=0 mid-run: busy=1 with phase restarted; reset clears out_valid and pending.
